// File: rtl/sr_cmd_sequencer.sv
// Command sequencer for a master(SR)/slave(D) flip-flop pair.
// Commands arrive over valid/ready and wait in a small FIFO. Each one drives s/r
// for a fixed number of cycles. The pair's outputs are then checked until they
// agree with the command, or until the timeout expires.
module sr_cmd_sequencer #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 2,
    parameter int TIMEOUT     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    input  logic                     cmd_set,
    output logic                     cmd_ready,
    output logic                     s,
    output logic                     r,
    input  logic                     qm,
    input  logic                     qbm,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

    state_t          state, state_next;
    logic            mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   count;
    logic            push, pop, head;
    logic            target, target_next;
    logic            s_next;
    logic [HW-1:0]   hold_cnt, hold_next;
    logic [TW-1:0]   to_cnt, to_next;
    logic            done_next, err_next;

    assign cmd_ready = (count < LW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem[rd_ptr];
    assign level     = count;
    assign busy      = (state != IDLE) || (count != '0);

    // FIFO storage: written on accepted commands only, never reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cmd_set;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sequencer next-state logic: pop in IDLE, hold in DRIVE, compare in CHECK
    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        s_next      = s;
        target_next = target;
        hold_next   = hold_cnt;
        to_next     = to_cnt;
        done_next   = 1'b0;
        err_next    = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop         = 1'b1;
                    s_next      = head;
                    target_next = head;
                    hold_next   = HW'(HOLD_CYCLES);
                    state_next  = DRIVE;
                end
            end
            DRIVE: begin
                hold_next = hold_cnt - 1'b1;
                if (hold_cnt == HW'(1)) begin
                    to_next    = TW'(TIMEOUT);
                    state_next = CHECK;
                end
            end
            CHECK: begin
                // Case equality so an unsettled (x/z) pair never counts as confirmed
                if ((qm === target) && (qbm === ~target)) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else if (to_cnt == TW'(1)) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    to_next = to_cnt - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and control registers; reset drives the pair toward clear (s=0, r=1)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            s        <= 1'b0;
            r        <= 1'b1;
            hold_cnt <= '0;
            to_cnt   <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_next;
            s        <= s_next;
            r        <= ~s_next;
            hold_cnt <= hold_next;
            to_cnt   <= to_next;
            done     <= done_next;
            err      <= err_next;
        end
    end

    // Expected pair value for the command in flight
    always_ff @(posedge clk) begin
        target <= target_next;
    end

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Bench for sr_cmd_sequencer: an ideal SR/D pair model with fault injection,
// a transaction-level reference model compared every cycle, and directed
// literal checks on the documented latencies.
module tb_sr_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int HOLD  = 2;
    localparam int TO    = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_set = 1'b0;
    logic       cmd_ready, s, r, busy, done, err;
    logic [2:0] level;
    logic       qm, qbm;

    logic       mq, qm_i;
    logic       pair_on = 1'b1;
    logic       pair_x  = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    bit done_qm[$];

    sr_cmd_sequencer #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_set(cmd_set),
        .cmd_ready(cmd_ready), .s(s), .r(r), .qm(qm), .qbm(qbm),
        .busy(busy), .done(done), .err(err), .level(level)
    );

    always #5 clk = ~clk;

    // Downstream pair: SR master on posedge, D slave on negedge
    always @(posedge clk) begin
        if (pair_on) begin
            if (s && !r)      mq <= 1'b1;
            else if (r && !s) mq <= 1'b0;
        end
    end
    always @(negedge clk) qm_i <= mq;
    assign qm  = pair_x ? 1'bx : qm_i;
    assign qbm = pair_x ? 1'bx : ~qm_i;

    // Reference model: queue of commands plus elapsed time of the active one
    bit m_q[$];
    bit m_active = 1'b0;
    int m_t = 0;
    bit m_s = 1'b0;
    bit m_tgt = 1'b0;
    bit m_done = 1'b0;
    bit m_err = 1'b0;
    int m_sz;
    bit m_push;
    bit m_val;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_active = 1'b0;
            m_s      = 1'b0;
            m_done   = 1'b0;
            m_err    = 1'b0;
        end else begin
            m_sz   = m_q.size();
            m_push = cmd_valid && (m_sz < DEPTH);
            m_val  = cmd_set;
            m_done = 1'b0;
            m_err  = 1'b0;
            if (!m_active) begin
                if (m_sz > 0) begin
                    m_tgt    = m_q.pop_front();
                    m_s      = m_tgt;
                    m_active = 1'b1;
                    m_t      = 0;
                end
            end else begin
                m_t++;
                if (m_t > HOLD) begin
                    if (qm === m_tgt && qbm === !m_tgt) begin
                        m_done   = 1'b1;
                        m_active = 1'b0;
                    end else if (m_t == HOLD + TO) begin
                        m_err    = 1'b1;
                        m_active = 1'b0;
                    end
                end
            end
            if (m_push) m_q.push_back(m_val);
        end
    end

    // Every-cycle comparison of all outputs against the model
    logic [8:0] act_v, exp_v;
    always @(posedge clk) begin
        #1;
        act_v = {cmd_ready, s, r, busy, done, err, level};
        exp_v = {m_q.size() < DEPTH, m_s, !m_s, m_active || (m_q.size() > 0),
                 m_done, m_err, 3'(m_q.size())};
        n_checks++;
        if (act_v !== exp_v)
            $display("FAIL cycle_compare t=%0t {rdy,s,r,busy,done,err,level}: got %b expected %b",
                     $time, act_v, exp_v);
        else
            n_pass++;
        if (done) begin
            done_cnt++;
            done_qm.push_back(qm);
        end
        if (err) err_cnt++;
    end

    task automatic chk(string nm, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int d0, e0;
    bit exp_seq[4];

    initial begin
        // Reset
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_level", level, 0);
        chk("rst_s", s, 0);
        chk("rst_r", r, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", cmd_ready, 1);

        // Single set command, latency pinned edge by edge
        cmd_valid = 1'b1; cmd_set = 1'b1;
        tick();                                  // edge 0
        cmd_valid = 1'b0;
        chk("t1_level_e0", level, 1);
        chk("t1_s_e0", s, 0);
        tick();                                  // edge 1
        chk("t1_s_e1", s, 1);
        chk("t1_r_e1", r, 0);
        chk("t1_busy_e1", busy, 1);
        tick(); tick();                          // edges 2,3
        chk("t1_done_e3", done, 0);
        tick();                                  // edge 4
        chk("t1_done_e4", done, 1);
        tick();                                  // edge 5
        chk("t1_done_e5", done, 0);
        chk("t1_busy_e5", busy, 0);

        // Back-to-back set,clear,set,clear
        done_qm.delete();
        exp_seq[0] = 1; exp_seq[1] = 0; exp_seq[2] = 1; exp_seq[3] = 0;
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1; cmd_set = exp_seq[i];
            tick();
        end
        cmd_valid = 1'b0;
        repeat (20) tick();
        chk("t2_done_count", done_qm.size(), 4);
        for (int i = 0; i < 4 && i < done_qm.size(); i++)
            chk($sformatf("t2_qm_%0d", i), done_qm[i], exp_seq[i]);

        // Stuck pair: set times out at edge 11, queued clear then completes
        pair_on = 1'b0;
        d0 = done_cnt; e0 = err_cnt;
        cmd_valid = 1'b1; cmd_set = 1'b1;
        tick();                                  // edge 0
        cmd_set = 1'b0;
        tick();                                  // edge 1
        cmd_valid = 1'b0;
        chk("t3_s_e1", s, 1);
        repeat (9) tick();                       // edge 10
        chk("t3_err_e10", err, 0);
        tick();                                  // edge 11
        chk("t3_err_e11", err, 1);
        chk("t3_done_e11", done, 0);
        chk("t3_s_e11", s, 1);
        tick();                                  // edge 12
        chk("t3_s_e12", s, 0);
        repeat (3) tick();                       // edge 15
        chk("t3_done_e15", done, 1);
        chk("t3_done_total", done_cnt - d0, 1);
        chk("t3_err_total", err_cnt - e0, 1);
        pair_on = 1'b1;
        repeat (3) tick();

        // Reset during DRIVE with 3 queued
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1; cmd_set = (i % 2 == 0);
            tick();
        end
        cmd_valid = 1'b0;
        tick();                                  // edge 5: second command popped
        chk("t4_level_pre", level, 3);
        rst_n = 1'b0;
        #1;
        chk("t4_level", level, 0);
        chk("t4_s", s, 0);
        chk("t4_r", r, 1);
        chk("t4_busy", busy, 0);
        tick(); tick();
        rst_n = 1'b1;
        d0 = done_cnt; e0 = err_cnt;
        repeat (12) tick();
        chk("t4_no_done", done_cnt - d0, 0);
        chk("t4_no_err", err_cnt - e0, 0);

        // Full FIFO with cmd_valid held through an IDLE pop
        cmd_valid = 1'b1; cmd_set = 1'b1;
        repeat (5) tick();                       // edges 0..4
        chk("t5_level_e4", level, 4);
        chk("t5_ready_e4", cmd_ready, 0);
        tick();                                  // edge 5: pop, push refused
        chk("t5_level_e5", level, 3);
        tick();                                  // edge 6: push accepted
        chk("t5_level_e6", level, 4);
        cmd_valid = 1'b0;
        repeat (25) tick();
        chk("t5_drained", busy, 0);

        // Unsettled (x) pair: mismatch until it settles, then done
        d0 = done_cnt; e0 = err_cnt;
        pair_x = 1'b1;
        cmd_valid = 1'b1; cmd_set = 1'b0;
        tick();                                  // edge 0
        cmd_valid = 1'b0;
        repeat (4) tick();                       // edge 4
        chk("t6_done_e4", done, 0);
        repeat (2) tick();                       // edge 6
        pair_x = 1'b0;
        repeat (6) tick();
        chk("t6_done_total", done_cnt - d0, 1);
        chk("t6_err_total", err_cnt - e0, 0);

        // Randomized traffic with pair outages and x glitches
        for (int i = 0; i < 800; i++) begin
            cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_set   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 29) == 0) pair_on = ~pair_on;
            pair_x = ($urandom_range(0, 19) == 0);
            tick();
        end
        cmd_valid = 1'b0;
        pair_on   = 1'b1;
        pair_x    = 1'b0;
        repeat (80) tick();
        chk("final_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
